// File: rtl/ifetch_queue_if.sv
// Fetch-unit bus: ICache request/return handshake, redirect strobe and decode-side valid/ready.
interface ifetch_queue_if;
   logic [14:0] ic_addr;
   logic        ic_vld;
   logic        ic_page_spill;
   logic        ic_read;
   logic        ic_data_vld;
   logic [63:0] ic_data;
   logic [14:0] ic_addrout;
   logic        redir_vld;
   logic [14:0] redir_pc;
   logic        instr_vld;
   logic        instr_rdy;
   logic [31:0] instr_out;
   logic [14:0] instr_pc;

   modport master (
      output ic_addr, ic_vld, ic_page_spill, instr_vld, instr_out, instr_pc,
      input  ic_read, ic_data_vld, ic_data, ic_addrout, redir_vld, redir_pc, instr_rdy
   );

   modport slave (
      input  ic_addr, ic_vld, ic_page_spill, instr_vld, instr_out, instr_pc,
      output ic_read, ic_data_vld, ic_data, ic_addrout, redir_vld, redir_pc, instr_rdy
   );
endinterface

// File: rtl/ifetch_queue.sv
// Sequential line fetcher feeding a DEPTH-line FIFO; a returned line reaches instr_vld one cycle later.
// Backpressure: instr_rdy=0 holds the head; no request issues while every FIFO slot is occupied.
module ifetch_queue #(
   parameter int          DEPTH     = 4,
   parameter logic [14:0] RESET_PC  = 15'h0000,
   parameter int          PAGE_BITS = 9
) (
   input logic           clk,
   input logic           rst,
   ifetch_queue_if.master bus
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   typedef struct packed {
      logic [63:0] dat;
      logic [11:0] line;
      logic        start_hi;
   } line_t;

   state_t      state, state_nxt;
   logic [14:0] addr_q, addr_nxt;
   logic        kill_q, kill_nxt;
   logic        shi_q, shi_nxt;
   logic        push;

   line_t       mem [DEPTH];
   line_t       in_line, head;
   logic [PW-1:0] rd_ptr, wr_ptr, rd_nxt;
   logic [PW:0] count, count_nxt;
   logic        half, half_nxt, sel;
   logic        hs, pop, eff_hi;
   logic        vld_q;
   logic [31:0] out_q;
   logic [14:0] pc_q;
   logic        unused_bits;

   assign unused_bits = ^{bus.redir_pc[1:0], bus.ic_addrout[2:0]};

   always_comb begin
      state_nxt = state;
      addr_nxt  = addr_q;
      kill_nxt  = kill_q;
      shi_nxt   = shi_q;
      push      = 1'b0;
      case (state)
         IDLE: if (count != DEPTH_C) state_nxt = REQ;
         REQ:  if (bus.ic_read) state_nxt = WAIT;
         WAIT: if (bus.ic_data_vld) begin
            state_nxt = IDLE;
            if (kill_q) begin
               kill_nxt = 1'b0;
            end else begin
               push     = 1'b1;
               shi_nxt  = 1'b0;
               addr_nxt = addr_q + 15'd8;
            end
         end
         default: state_nxt = IDLE;
      endcase
      // Redirect overrides everything; a request already accepted must still be drained and dropped.
      if (bus.redir_vld) begin
         push     = 1'b0;
         addr_nxt = {bus.redir_pc[14:3], 3'b000};
         shi_nxt  = bus.redir_pc[2];
         case (state)
            REQ: begin
               state_nxt = bus.ic_read ? WAIT : IDLE;
               kill_nxt  = bus.ic_read;
            end
            WAIT: begin
               state_nxt = bus.ic_data_vld ? IDLE : WAIT;
               kill_nxt  = ~bus.ic_data_vld;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign bus.ic_vld        = (state == REQ);
   assign bus.ic_addr       = addr_q;
   assign bus.ic_page_spill = (state == REQ) && (&addr_q[PAGE_BITS-1:3]);

   assign in_line = '{dat: bus.ic_data, line: bus.ic_addrout[14:3], start_hi: shi_q};
   assign hs      = vld_q & bus.instr_rdy;
   assign eff_hi  = half | mem[rd_ptr].start_hi;
   assign pop     = hs & eff_hi;

   // Outputs are registered, so the next head is chosen from post-update state (bypassing an empty FIFO).
   always_comb begin
      rd_nxt    = rd_ptr + PW'(pop);
      count_nxt = count + (PW+1)'(push) - (PW+1)'(pop);
      half_nxt  = hs ? ~pop : half;
      head      = (count != (PW+1)'(pop)) ? mem[rd_nxt] : in_line;
      sel       = half_nxt | head.start_hi;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         addr_q <= {RESET_PC[14:3], 3'b000};
         kill_q <= 1'b0;
         shi_q  <= RESET_PC[2];
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         half   <= 1'b0;
         vld_q  <= 1'b0;
         out_q  <= '0;
         pc_q   <= '0;
      end else begin
         state  <= state_nxt;
         addr_q <= addr_nxt;
         kill_q <= kill_nxt;
         shi_q  <= shi_nxt;
         if (bus.redir_vld) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            half   <= 1'b0;
            vld_q  <= 1'b0;
         end else begin
            rd_ptr <= rd_nxt;
            wr_ptr <= wr_ptr + PW'(push);
            count  <= count_nxt;
            half   <= half_nxt;
            vld_q  <= (count_nxt != '0);
            if (count_nxt != '0) begin
               out_q <= sel ? head.dat[63:32] : head.dat[31:0];
               pc_q  <= {head.line, sel, 2'b00};
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_line;
   end

   assign bus.instr_vld = vld_q;
   assign bus.instr_out = out_q;
   assign bus.instr_pc  = pc_q;
endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench: ICache model plus scoreboard queues for requests and delivered instructions.
module tb_ifetch_queue;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ifetch_queue_if ifq();

   ifetch_queue #(.DEPTH(4), .RESET_PC(15'h0100), .PAGE_BITS(9)) dut (
      .clk(clk), .rst(rst), .bus(ifq)
   );

   typedef struct { logic [14:0] pc; logic [31:0] w; } ins_t;
   typedef struct { logic [14:0] a;  logic s; }       req_t;

   ins_t exp_ins[$];
   req_t exp_req[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   hs_count = 0;
   int   req_total = 0;
   bit   mem_en;
   int   ret_delay;
   int   read_hold;

   // Memory contents: the word at byte address a.
   function automatic logic [31:0] wd(input logic [14:0] a);
      return {8'hA5, 9'h000, a};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic exp_i(input logic [14:0] pc);
      ins_t e;
      e.pc = pc;
      e.w  = wd(pc);
      exp_ins.push_back(e);
   endtask

   task automatic exp_r(input logic [14:0] a, input logic s);
      req_t e;
      e.a = a;
      e.s = s;
      exp_req.push_back(e);
   endtask

   // ICache model: accepts after read_hold cycles, returns the line ret_delay cycles after accept.
   initial begin
      logic [14:0] a;
      ifq.ic_read = 1'b0;
      ifq.ic_data_vld = 1'b0;
      ifq.ic_data = '0;
      ifq.ic_addrout = '0;
      forever begin
         @(posedge clk); #1;
         if (rst === 1'b1 && mem_en && ifq.ic_vld === 1'b1) begin
            a = ifq.ic_addr;
            for (int i = 0; i < read_hold; i++) begin
               @(posedge clk); #1;
               chk("hold_vld", ifq.ic_vld, 1);
               chk("hold_addr", ifq.ic_addr, a);
            end
            ifq.ic_read = 1'b1;
            @(posedge clk); #1;
            ifq.ic_read = 1'b0;
            repeat (ret_delay - 1) begin @(posedge clk); #1; end
            ifq.ic_data_vld = 1'b1;
            ifq.ic_data = {wd(a + 15'd4), wd(a)};
            ifq.ic_addrout = a;
            @(posedge clk); #1;
            ifq.ic_data_vld = 1'b0;
         end
      end
   end

   // Monitor: pops expectations whenever the DUT completes a handshake.
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         if (ifq.instr_vld && ifq.instr_rdy) begin
            hs_count++;
            if (exp_ins.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_instr: got pc %0h, expected none", ifq.instr_pc);
            end else begin
               ins_t e;
               e = exp_ins.pop_front();
               chk("instr_pc", ifq.instr_pc, e.pc);
               chk("instr_out", ifq.instr_out, e.w);
            end
         end
         if (ifq.ic_vld && ifq.ic_read && !ifq.redir_vld) begin
            req_total++;
            if (exp_req.size() != 0) begin
               req_t r;
               r = exp_req.pop_front();
               chk("ic_addr", ifq.ic_addr, r.a);
               chk("ic_page_spill", ifq.ic_page_spill, r.s);
            end
         end
      end
   end

   task automatic redirect(input logic [14:0] pc);
      @(posedge clk); #1;
      ifq.redir_vld = 1'b1;
      ifq.redir_pc = pc;
      @(posedge clk); #1;
      ifq.redir_vld = 1'b0;
   endtask

   task automatic quiesce();
      mem_en = 1'b0;
      ifq.instr_rdy = 1'b0;
      repeat (25) @(posedge clk);
      #1;
   endtask

   task automatic consume(input int n);
      int target;
      int t;
      target = hs_count + n;
      t = 0;
      @(posedge clk); #1;
      ifq.instr_rdy = 1'b1;
      while (hs_count < target && t < 300) begin
         @(posedge clk); #1;
         t++;
      end
      ifq.instr_rdy = 1'b0;
      chk("consume_count", hs_count, target);
      chk("ins_drained", exp_ins.size(), 0);
   endtask

   task automatic wait_read();
      int t;
      t = 0;
      while (ifq.ic_read !== 1'b1 && t < 100) begin
         @(posedge clk); #2;
         t++;
      end
      chk("wait_read", ifq.ic_read, 1);
   endtask

   task automatic chk_reset_outputs();
      chk("rst_ic_vld", ifq.ic_vld, 0);
      chk("rst_ic_addr", ifq.ic_addr, 15'h0100);
      chk("rst_spill", ifq.ic_page_spill, 0);
      chk("rst_instr_vld", ifq.instr_vld, 0);
      chk("rst_instr_out", ifq.instr_out, 0);
      chk("rst_instr_pc", ifq.instr_pc, 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached, hs=%0d req=%0d", hs_count, req_total);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      ifq.instr_rdy = 1'b0;
      ifq.redir_vld = 1'b0;
      ifq.redir_pc = '0;
      mem_en = 1'b1;
      ret_delay = 3;
      read_hold = 0;
      #1 rst = 1'b0;
      #12;
      chk_reset_outputs();

      // Fill with decode stalled: exactly DEPTH requests, then fetch stops.
      exp_r(15'h0100, 0); exp_r(15'h0108, 0); exp_r(15'h0110, 0); exp_r(15'h0118, 0);
      exp_i(15'h0100);
      @(posedge clk); #1 rst = 1'b1;
      repeat (60) @(posedge clk);
      #1;
      chk("full_req_total", req_total, 4);
      chk("full_ic_vld", ifq.ic_vld, 0);
      chk("full_instr_vld", ifq.instr_vld, 1);
      chk("full_head_pc", ifq.instr_pc, 15'h0100);
      chk("full_req_drained", exp_req.size(), 0);

      // Lower word taken: no slot freed yet.
      ifq.instr_rdy = 1'b1;
      @(posedge clk); #1;
      ifq.instr_rdy = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      chk("half_req_total", req_total, 4);
      chk("half_head_pc", ifq.instr_pc, 15'h0104);

      // Upper word taken: line pops and one request issues.
      exp_i(15'h0104);
      exp_r(15'h0120, 0);
      ifq.instr_rdy = 1'b1;
      @(posedge clk); #1;
      ifq.instr_rdy = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      chk("pop_req_total", req_total, 5);
      chk("pop_req_drained", exp_req.size(), 0);
      for (int i = 0; i < 8; i++) exp_i(15'h0108 + 15'(4 * i));
      consume(8);
      quiesce();

      // Redirect while a request is outstanding: stale line dropped, upper word first.
      exp_r(15'h0400, 0);
      ret_delay = 10;
      redirect(15'h0400);
      mem_en = 1'b1;
      wait_read();
      @(posedge clk); #1;
      exp_r(15'h0230, 0); exp_r(15'h0238, 0);
      redirect(15'h0234);
      ret_delay = 3;
      chk("redir_instr_vld", ifq.instr_vld, 0);
      chk("redir_ic_addr", ifq.ic_addr, 15'h0230);
      exp_i(15'h0234); exp_i(15'h0238); exp_i(15'h023C);
      consume(3);
      quiesce();
      chk("redir_req_drained", exp_req.size(), 0);

      // Page spill on the last line of a 512-byte page.
      exp_r(15'h01F8, 1); exp_r(15'h0200, 0);
      redirect(15'h01F8);
      mem_en = 1'b1;
      exp_i(15'h01F8); exp_i(15'h01FC); exp_i(15'h0200); exp_i(15'h0204);
      consume(4);
      quiesce();
      chk("spill_req_drained", exp_req.size(), 0);

      // Slow accept with address wrap at the top of the space.
      read_hold = 5;
      exp_r(15'h7FF8, 1); exp_r(15'h0000, 0);
      redirect(15'h7FF8);
      mem_en = 1'b1;
      exp_i(15'h7FF8); exp_i(15'h7FFC); exp_i(15'h0000); exp_i(15'h0004);
      consume(4);
      quiesce();
      read_hold = 0;
      chk("wrap_req_drained", exp_req.size(), 0);

      // Reset while waiting for a line; the late return must be ignored.
      ret_delay = 6;
      exp_r(15'h0500, 0);
      redirect(15'h0500);
      mem_en = 1'b1;
      wait_read();
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk_reset_outputs();
      chk("pre_rst_req_drained", exp_req.size(), 0);
      exp_r(15'h0100, 0); exp_r(15'h0108, 0);
      exp_i(15'h0100); exp_i(15'h0104); exp_i(15'h0108); exp_i(15'h010C);
      ret_delay = 3;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      consume(4);
      quiesce();
      chk("final_req_drained", exp_req.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction-fetch front end directly upstream of the memory subsystem's ICache port.
- Generates sequential 8-byte-aligned fetch addresses and runs the ic_vld/ic_read/ic_data_vld handshake.
- Buffers returned 64-bit lines in a small FIFO and hands 32-bit instructions one at a time to decode.
- Handles PC redirects (branch/interrupt) by flushing and discarding stale returns.

Parameters:
- DEPTH, 4, number of 64-bit line entries in the FIFO (power of 2, >=2).
- RESET_PC, 15'h0000, byte address fetched first after reset.
- PAGE_BITS, 9, log2 page size in bytes; drives ic_page_spill.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- ic_addr  output  15  fetch line address, bits [2:0] always 0
- ic_vld  output  1  fetch request valid
- ic_page_spill  output  1  requested line is the last line of its page
- ic_read  input  1  one-cycle strobe: request accepted
- ic_data_vld  input  1  one-cycle strobe: line returned
- ic_data  input  64  returned line; [31:0] = instruction at +0, [63:32] = instruction at +4
- ic_addrout  input  15  line address of the returned data
- redir_vld  input  1  redirect strobe
- redir_pc  input  15  redirect target, bits [1:0] ignored
- instr_vld  output  1  instr_out valid
- instr_rdy  input  1  decode accepts instr_out this cycle
- instr_out  output  32  instruction
- instr_pc  output  15  byte address of instr_out

Behaviour:
- Reset (rst=0, async): ic_vld=0; ic_addr={RESET_PC[14:3],3'b0}; ic_page_spill=0; FIFO empty; instr_vld=0; instr_out=0; instr_pc=0; kill=0; start_hi=RESET_PC[2]; FSM=IDLE.
- Fetch FSM states:
  - IDLE: if entries+1 <= DEPTH (free slot reserved for the outstanding line), drive ic_vld=1 next cycle -> REQ.
  - REQ: hold ic_vld, ic_addr and ic_page_spill stable until ic_read=1. On ic_read: ic_vld=0 the same edge, -> WAIT.
  - WAIT: on ic_data_vld with kill=0, push {ic_data, ic_addrout, start_hi} into the FIFO; clear start_hi; ic_addr += 8 (15-bit wrap 7FF8 -> 0000) -> IDLE. Max one outstanding request.
- ic_page_spill = (ic_addr[PAGE_BITS-1:3] all ones) while ic_vld=1, else 0.
- Output side:
  - Head entry presents the lower word, then the upper word.
  - An entry with start_hi=1 presents the upper word only.
  - instr_pc = line address + 0 or + 4.
  - instr_vld is registered; a head change appears the cycle after the handshake.
  - On instr_vld & instr_rdy: advance the half pointer; pop the entry after the upper word.
  - Push and pop in the same cycle keep the count unchanged.
  - Fill-to-use latency: a line returned on cycle N gives instr_vld=1 on cycle N+1 when the FIFO was empty.
- Redirect (redir_vld=1, highest priority):
  - Same edge: FIFO flushed; instr_vld=0; ic_addr={redir_pc[14:3],3'b0}; start_hi=redir_pc[2].
  - In REQ: ic_vld drops and the FSM returns to IDLE; a new request issues next cycle. An ic_read in the same cycle is treated as accepted-and-killed.
  - In WAIT (or REQ+ic_read): set kill=1. The next ic_data_vld is discarded, clears kill and returns to IDLE without incrementing ic_addr.
  - Redirect coinciding with ic_data_vld: data discarded, kill not set.
- Full: no request is issued while entries == DEPTH; ic_vld stays 0.
- Empty: instr_vld=0, and instr_out/instr_pc hold their last values.
- An ic_data_vld outside WAIT is ignored.

Test Plan:
- Reset with RESET_PC=15'h0100; memory model returns lines after 3 cycles -> ic_addr sequence 0100, 0108, 0110; decode sees instr_pc 0100, 0104, 0108, 010C with matching words.
- instr_rdy=0 permanently, DEPTH=4 -> exactly 4 requests issued, ic_vld stays 0 afterwards. One instr_rdy pulse frees no slot until the second word of that line is taken.
- Redirect to 15'h0234 while in WAIT -> stale line dropped; next ic_addr=0230; first instruction delivered has instr_pc=0234 (lower word skipped).
- ic_addr=01F8 with PAGE_BITS=9 -> ic_page_spill=1 during the request; at 0200 -> ic_page_spill=0.
- Hold ic_read low for 5 cycles -> ic_vld and ic_addr stable for all 5; one request recorded. ic_addr=7FF8 then wraps to 0000.
- Assert rst low mid-WAIT, then release -> all outputs at reset values and fetch restarts at RESET_PC; a late ic_data_vld right after reset is ignored.
